// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse generator / pulse measurement pair.
//   CNT_W_DEFAULT : default width of the width/period counters, so both ends
//                   of a loop-back self-test agree on the counting range.
//   meas_state_t  : measurement FSM state encoding (IDLE, HIGH, LOW).
// -----------------------------------------------------------------------------
package pulse_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous pin into the clk domain through a SYNC_STAGES-deep
// flop chain and derives single-cycle rise/fall pulses from the synchronised
// level. Edges appear SYNC_STAGES+1 cycles after the pin changes once they
// are consumed by a register.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset, clears every flop
//   d_async : asynchronous input pin
//   level   : synchronised level
//   rise    : one-cycle pulse on a 0->1 transition of level
//   fall    : one-cycle pulse on a 1->0 transition of level
// SYNC_STAGES is intended to be 2 or 3.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_d_r;

    // Synchroniser chain plus one delayed copy of the synchronised level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r    <= '0;
            level_d_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], d_async};
            level_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign rise  = sync_r[SYNC_STAGES-1] & ~level_d_r;
    assign fall  = ~sync_r[SYNC_STAGES-1] & level_d_r;

endmodule

// File: rtl/pulse_measure.sv
// -----------------------------------------------------------------------------
// pulse_measure
// Measures the high time and the rising-to-rising period of an external pulse
// train, in clk cycles. The first rising edge after IDLE only arms the
// measurement; every following rising edge publishes the previous pulse's
// width/period with a one-cycle meas_valid strobe. If the period counter
// reaches its maximum without a completing edge, a one-cycle timeout strobe
// is raised and the FSM returns to IDLE (counters never wrap).
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   en          : measurement enable, low forces IDLE and suppresses strobes
//   pulse_in    : asynchronous pulse train under test
//   meas_width  : width of the last complete pulse (cycles)
//   meas_period : rising-to-rising period of the last complete pulse (cycles)
//   meas_valid  : one-cycle strobe, new meas_width/meas_period
//   timeout     : one-cycle strobe, period reached max with no completing edge
//   busy        : FSM is not in IDLE
// -----------------------------------------------------------------------------
module pulse_measure
    import pulse_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             level_s;
    logic             rise_s;
    logic             fall_s;

    meas_state_t      state_r;
    logic [CNT_W-1:0] width_cnt_r;
    logic [CNT_W-1:0] period_cnt_r;
    logic [CNT_W-1:0] meas_width_r;
    logic [CNT_W-1:0] meas_period_r;
    logic             meas_valid_r;
    logic             timeout_r;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (pulse_in),
        .level   (level_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // Measurement FSM with counters, result registers and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            width_cnt_r   <= '0;
            period_cnt_r  <= '0;
            meas_width_r  <= '0;
            meas_period_r <= '0;
            meas_valid_r  <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            // Strobes are single-cycle; only the branches below raise them.
            meas_valid_r <= 1'b0;
            timeout_r    <= 1'b0;
            if (!en) begin
                // Results hold; a new arming rise is needed after re-enable.
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rise_s) begin
                            width_cnt_r  <= CNT_ONE;
                            period_cnt_r <= CNT_ONE;
                            state_r      <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        // A rise cannot occur here, so any cycle at max times out.
                        if (period_cnt_r == CNT_MAX) begin
                            timeout_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            period_cnt_r <= period_cnt_r + CNT_ONE;
                            if (fall_s) begin
                                state_r <= ST_LOW;
                            end else if (level_s) begin
                                width_cnt_r <= width_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_LOW: begin
                        // Rise has priority over timeout, so period==max is reportable.
                        if (rise_s) begin
                            meas_width_r  <= width_cnt_r;
                            meas_period_r <= period_cnt_r;
                            meas_valid_r  <= 1'b1;
                            width_cnt_r   <= CNT_ONE;
                            period_cnt_r  <= CNT_ONE;
                            state_r       <= ST_HIGH;
                        end else if (period_cnt_r == CNT_MAX) begin
                            timeout_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            period_cnt_r <= period_cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign meas_width  = meas_width_r;
    assign meas_period = meas_period_r;
    assign meas_valid  = meas_valid_r;
    assign timeout     = timeout_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_pulse_measure.sv
// -----------------------------------------------------------------------------
// tb_pulse_measure
// Drives pulse trains as (high, low) segment pairs. A pulse-level reference
// model turns each rising edge into expected strobes (kind, values, arrival
// cycle) pushed onto a queue; an independent monitor pops and compares
// whenever the DUT raises meas_valid or timeout.
// -----------------------------------------------------------------------------
module tb_pulse_measure;

    localparam int CNT_W  = 8;
    localparam int SYNC   = 2;
    localparam int MAX    = 255;
    localparam int LAT    = SYNC + 1;
    localparam int TO_LAT = LAT + MAX;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pulse_in;
    logic [CNT_W-1:0] meas_width;
    logic [CNT_W-1:0] meas_period;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    pulse_measure #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pulse_in    (pulse_in),
        .meas_width  (meas_width),
        .meas_period (meas_period),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int w;
        int p;
        int t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Pulse-level reference model state.
    bit armed = 1'b0;
    int prev_h = 0;
    int prev_l = 0;
    int last_w = 0;
    int last_p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A rising edge driven at cycle pd completes the armed pulse (if any) and
    // starts a new one whose period is h+l; a period beyond MAX times out.
    task automatic on_rise(input int h, input int l, input int pd);
        exp_t e;
        if (armed) begin
            last_w  = prev_h;
            last_p  = prev_h + prev_l;
            e.is_to = 1'b0;
            e.w     = last_w;
            e.p     = last_p;
            e.t     = pd + LAT;
            q.push_back(e);
        end
        if (h + l > MAX) begin
            e.is_to = 1'b1;
            e.w     = last_w;
            e.p     = last_p;
            e.t     = pd + TO_LAT;
            q.push_back(e);
            armed = 1'b0;
        end else begin
            armed  = 1'b1;
            prev_h = h;
            prev_l = l;
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        pulse_in = 1'b1;
        on_rise(h, l, cyc);
        repeat (h) @(negedge clk);
        pulse_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int w, input int p, input int bsy);
        chk({tag, "_width"}, meas_width, w);
        chk({tag, "_period"}, meas_period, p);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_busy"}, busy, bsy);
    endtask

    // Monitor: every DUT strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (meas_valid || timeout)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, meas_valid, timeout}, 0);
            end else begin
                mon_e = q.pop_front();
                chk("strobe_timeout", timeout, mon_e.is_to);
                chk("strobe_valid", meas_valid, !mon_e.is_to);
                chk("strobe_width", meas_width, mon_e.w);
                chk("strobe_period", meas_period, mon_e.p);
                chk("strobe_cycle", cyc, mon_e.t);
                chk("strobe_busy", busy, !mon_e.is_to);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // Steady train, then minimum pulses.
        for (int i = 0; i < 6; i++) send_pulse(5, 15);
        for (int i = 0; i < 6; i++) send_pulse(1, 1);
        for (int i = 0; i < 6; i++) send_pulse(1, 3);

        // Timeouts with the pin held low, then held high.
        send_pulse(1, 300);
        send_pulse(300, 5);

        // Boundary: period 255 is reported, period 256 times out.
        send_pulse(10, 245);
        send_pulse(10, 245);
        send_pulse(10, 246);
        send_pulse(10, 246);

        // Enable dropped in the middle of the third pulse.
        send_pulse(4, 6);
        send_pulse(4, 6);
        pulse_in = 1'b1;
        on_rise(20, 8, cyc);
        repeat (8) @(negedge clk);
        en    = 1'b0;
        armed = 1'b0;
        @(negedge clk);
        check_outputs("en_off", last_w, last_p, 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (8) @(negedge clk);
        pulse_in = 1'b0;
        repeat (8) @(negedge clk);
        send_pulse(5, 7);
        send_pulse(5, 7);
        send_pulse(6, 6);

        // Reset pulse while the FSM sits in LOW.
        send_pulse(3, 5);
        send_pulse(3, 5);
        pulse_in = 1'b1;
        on_rise(3, 12, cyc);
        repeat (3) @(negedge clk);
        pulse_in = 1'b0;
        repeat (5) @(negedge clk);
        rst    = 1'b1;
        armed  = 1'b0;
        last_w = 0;
        last_p = 0;
        @(negedge clk);
        check_outputs("mid_rst", 0, 0, 0);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 3; i++) send_pulse(4, 9);

        // Randomised trains, occasionally stretched around the max period.
        for (int i = 0; i < 40; i++) begin
            int h;
            int l;
            h = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) l = $urandom_range(230, 260);
            else                           l = $urandom_range(1, 20);
            send_pulse(h, l);
        end
        send_pulse(3, 300);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        repeat (20) @(negedge clk);
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
